// File: rtl/morse_letter_tx.sv
// Morse transmitter core: plays one letter A-H on Led using a unit-time divider.
// state | meaning
// IDLE  | waiting for Start; latches letter code on accept
// ON    | mark in progress (Led high) for the current symbol
// GAP   | one-unit space between symbols
// DONE  | one-cycle completion pulse after the last mark
module morse_letter_tx #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       Led,
  output logic       Busy,
  output logic       Done
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] div_cnt;
  logic [1:0]    unit;
  logic [3:0]    pattern;
  logic [2:0]    length;
  logic          tick;
  logic          accept;
  logic [3:0]    sel_pat;
  logic [2:0]    sel_len;

  assign tick   = (div_cnt == DIV_LAST);
  assign accept = (state == S_IDLE) && Start;

  // Pattern is MSB-first, 1 = dash; unused low bits are zero.
  always_comb begin
    sel_pat = 4'b0000;
    sel_len = 3'd1;
    case (Letter)
      3'd0: begin sel_pat = 4'b0100; sel_len = 3'd2; end
      3'd1: begin sel_pat = 4'b1000; sel_len = 3'd4; end
      3'd2: begin sel_pat = 4'b1010; sel_len = 3'd4; end
      3'd3: begin sel_pat = 4'b1000; sel_len = 3'd3; end
      3'd4: begin sel_pat = 4'b0000; sel_len = 3'd1; end
      3'd5: begin sel_pat = 4'b0010; sel_len = 3'd4; end
      3'd6: begin sel_pat = 4'b1100; sel_len = 3'd3; end
      default: begin sel_pat = 4'b0000; sel_len = 3'd4; end
    endcase
  end

  always_comb begin
    state_next = state;
    Led        = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: if (Start) state_next = S_ON;
      S_ON: begin
        Led  = 1'b1;
        Busy = 1'b1;
        if (tick && unit == 2'd1) state_next = (length > 3'd1) ? S_GAP : S_DONE;
      end
      S_GAP: begin
        Busy = 1'b1;
        if (tick) state_next = S_ON;
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      unit    <= 2'd0;
      pattern <= 4'b0000;
      length  <= 3'd0;
    end else begin
      state <= state_next;

      if (accept)
        div_cnt <= '0;
      else if (Busy)
        div_cnt <= tick ? '0 : div_cnt + 1'b1;

      case (state)
        S_IDLE: if (Start) begin
          pattern <= sel_pat;
          length  <= sel_len;
          unit    <= sel_pat[3] ? 2'd3 : 2'd1;
        end
        S_ON: if (tick) begin
          if (unit > 2'd1)
            unit <= unit - 2'd1;
          else if (length > 3'd1)
            unit <= 2'd1;
        end
        S_GAP: if (tick) begin
          // Next symbol sits in bit 2 before the shift takes effect.
          pattern <= {pattern[2:0], 1'b0};
          length  <= length - 3'd1;
          unit    <= pattern[2] ? 2'd3 : 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_letter_tx.sv
// Scoreboard bench for morse_letter_tx: two instances (TICK_DIV 4 and 2),
// expected Led run-lengths queued at stimulus time and checked on each Done.
module tb_morse_letter_tx;

  typedef struct {
    logic [63:0] runs;
    int          busy;
    int          lat;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic       start4, start2;
  logic [2:0] letter4, letter2;
  logic       led4, busy4, done4;
  logic       led2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q4[$];
  exp_t q2[$];

  logic [63:0] runs[2];
  int          nseg[2], seglen[2], bcnt[2], b_cyc[2], last_done[2];
  logic        cur_led[2], was_busy[2];

  morse_letter_tx #(.TICK_DIV(4)) dut_t4 (
    .Clock(Clock), .Reset(Reset), .Start(start4), .Letter(letter4),
    .Led(led4), .Busy(busy4), .Done(done4)
  );

  morse_letter_tx #(.TICK_DIV(2)) dut_t2 (
    .Clock(Clock), .Reset(Reset), .Start(start2), .Letter(letter2),
    .Led(led2), .Busy(busy2), .Done(done2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task mon(input int i, input logic led, input logic busy, input logic done);
    exp_t e;
    if (busy && !was_busy[i]) begin
      b_cyc[i] = cyc; runs[i] = '0; nseg[i] = 0; seglen[i] = 0; bcnt[i] = 0;
    end
    if (busy) begin
      bcnt[i]++;
      if (seglen[i] != 0 && led != cur_led[i]) begin
        if (nseg[i] < 8) runs[i][nseg[i]*8 +: 8] = 8'(seglen[i]);
        nseg[i]++;
        seglen[i] = 0;
      end
      cur_led[i] = led;
      seglen[i]++;
    end
    if (done) begin
      if (seglen[i] != 0) begin
        if (nseg[i] < 8) runs[i][nseg[i]*8 +: 8] = 8'(seglen[i]);
        nseg[i]++;
        seglen[i] = 0;
      end
      if ((i == 0 && q4.size() == 0) || (i == 1 && q2.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done inst=%0d actual=1 required=0", i);
      end else begin
        e = (i == 0) ? q4.pop_front() : q2.pop_front();
        chk($sformatf("runs%0d", i), runs[i], e.runs);
        chk($sformatf("busy_cycles%0d", i), 64'(bcnt[i]), 64'(e.busy));
        chk($sformatf("done_latency%0d", i), 64'(cyc - b_cyc[i] + 1), 64'(e.lat));
        chk($sformatf("led_at_done%0d", i), {63'b0, led}, 64'd0);
        chk($sformatf("done_spacing_ok%0d", i), {63'b0, (cyc - last_done[i]) > 1}, 64'd1);
      end
      last_done[i] = cyc;
    end
    was_busy[i] = busy;
  endtask

  always @(negedge Clock) begin
    mon(0, led4, busy4, done4);
    mon(1, led2, busy2, done2);
  end

  function automatic exp_t mk(input logic [63:0] r, input int b, input int l);
    exp_t e;
    e.runs = r; e.busy = b; e.lat = l;
    return e;
  endfunction

  task wait_idle(input int max);
    int n;
    n = 0;
    while ((q4.size() != 0 || q2.size() != 0 || busy4 || busy2 || done4 || done2) && n < max) begin
      @(negedge Clock);
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=%0d required<%0d", n, max);
    end
    @(negedge Clock);
  endtask

  task play(input int i, input logic [2:0] l, input exp_t e);
    @(negedge Clock);
    if (i == 0) begin q4.push_back(e); start4 = 1'b1; letter4 = l; end
    else        begin q2.push_back(e); start2 = 1'b1; letter2 = l; end
    @(negedge Clock);
    start4 = 1'b0; start2 = 1'b0;
    letter4 = 3'd7; letter2 = 3'd5;
    wait_idle(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dcyc;
    for (int i = 0; i < 2; i++) begin
      was_busy[i] = 1'b0; cur_led[i] = 1'b0; last_done[i] = -10;
      runs[i] = '0; nseg[i] = 0; seglen[i] = 0; bcnt[i] = 0; b_cyc[i] = 0;
    end
    Reset = 1'b1; start4 = 1'b0; start2 = 1'b0; letter4 = 3'd0; letter2 = 3'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("rst_led4", {63'b0, led4}, 64'd0);
    chk("rst_busy4", {63'b0, busy4}, 64'd0);
    chk("rst_done4", {63'b0, done4}, 64'd0);
    chk("rst_led2", {63'b0, led2}, 64'd0);
    chk("rst_busy2", {63'b0, busy2}, 64'd0);
    chk("rst_done2", {63'b0, done2}, 64'd0);

    play(0, 3'd4, mk(64'h04, 4, 5));
    play(0, 3'd0, mk(64'h0C_04_04, 20, 21));
    play(1, 3'd7, mk(64'h00_02_02_02_02_02_02_02, 14, 15));
    play(1, 3'd2, mk(64'h00_02_02_06_02_02_02_06, 22, 23));
    play(1, 3'd6, mk(64'h00_00_00_02_02_06_02_06, 18, 19));

    // Start held high with Letter churning: E plays, then A re-accepted from IDLE.
    @(negedge Clock);
    q4.push_back(mk(64'h04, 4, 5));
    q4.push_back(mk(64'h0C_04_04, 20, 21));
    start4 = 1'b1; letter4 = 3'd4;
    n = 0;
    while (n < 300) begin
      @(negedge Clock);
      n++;
      if (done4) break;
      letter4 = letter4 + 3'd1;
    end
    letter4 = 3'd0;
    dcyc = cyc;
    n = 0;
    while (!busy4 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("reaccept_gap", 64'(cyc - dcyc), 64'd2);
    while (n < 300) begin
      @(negedge Clock);
      n++;
      if (done4) break;
      letter4 = letter4 + 3'd3;
    end
    start4 = 1'b0;
    wait_idle(300);

    // Reset during the leading dash of B: no Done, then B plays cleanly.
    @(negedge Clock);
    start4 = 1'b1; letter4 = 3'd1;
    @(negedge Clock);
    start4 = 1'b0;
    repeat (5) @(negedge Clock);
    chk("pre_rst_led4", {63'b0, led4}, 64'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_led4", {63'b0, led4}, 64'd0);
    chk("abort_busy4", {63'b0, busy4}, 64'd0);
    chk("abort_done4", {63'b0, done4}, 64'd0);
    repeat (20) @(negedge Clock);
    play(0, 3'd1, mk(64'h00_04_04_04_04_04_04_0C, 36, 37));

    wait_idle(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
